// File: rtl/edge_threshold_binarizer.sv
// Binarizes an RGB565 edge-difference stream against a per-pixel threshold and
// reports per-line / per-frame edge-pixel counts, with a fixed two-cycle latency.
module edge_threshold_binarizer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_color,
    input  logic        frame_start,
    input  logic [7:0]  threshold,
    output logic        out_valid,
    output logic [15:0] out_color,
    output logic        out_edge,
    output logic [9:0]  line_count,
    output logic        line_count_valid,
    output logic [18:0] frame_count,
    output logic        frame_done
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    // Handshake: in_valid/out_valid are plain qualifiers, no backpressure.

    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;

    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_m_q, s1_m_d;
    logic [7:0]  s1_thr_q, s1_thr_d;
    logic [9:0]  s1_x_q, s1_x_d;
    logic        s1_last_line_q, s1_last_line_d;
    logic        s1_last_frame_q, s1_last_frame_d;
    logic        s1_restart_q, s1_restart_d;

    logic        out_valid_q, out_valid_d;
    logic        out_edge_q, out_edge_d;
    logic [15:0] out_color_q, out_color_d;
    logic [9:0]  line_acc_q, line_acc_d;
    logic [18:0] frame_acc_q, frame_acc_d;
    logic [9:0]  line_count_q, line_count_d;
    logic [18:0] frame_count_q, frame_count_d;
    logic        line_pulse_q, line_pulse_d;
    logic        frame_pulse_q, frame_pulse_d;

    logic [9:0]  cur_x;
    logic [8:0]  cur_y;
    logic        is_last_x, is_last_y;
    logic [7:0]  m_in;
    logic        edge_w;
    logic [9:0]  line_sum;
    logic [18:0] frame_sum;

    // Stage 1: raster position and magnitude capture.
    always_comb begin
        cur_x     = (in_valid && frame_start) ? 10'd0 : x_q;
        cur_y     = (in_valid && frame_start) ? 9'd0 : y_q;
        is_last_x = (cur_x == X_LAST);
        is_last_y = (cur_y == Y_LAST);
        m_in      = 8'({in_color[15:11], 1'b0}) + 8'(in_color[10:5])
                  + 8'({in_color[4:0], 1'b0});

        x_d             = x_q;
        y_d             = y_q;
        s1_valid_d      = in_valid;
        s1_m_d          = s1_m_q;
        s1_thr_d        = s1_thr_q;
        s1_x_d          = s1_x_q;
        s1_last_line_d  = s1_last_line_q;
        s1_last_frame_d = s1_last_frame_q;
        s1_restart_d    = s1_restart_q;

        if (in_valid) begin
            s1_m_d          = m_in;
            s1_thr_d        = threshold;
            s1_x_d          = cur_x;
            s1_last_line_d  = is_last_x;
            s1_last_frame_d = is_last_x && is_last_y;
            s1_restart_d    = frame_start;
            if (is_last_x) begin
                x_d = 10'd0;
                y_d = is_last_y ? 9'd0 : cur_y + 9'd1;
            end else begin
                x_d = cur_x + 10'd1;
                y_d = cur_y;
            end
        end
    end

    // Stage 2: threshold decision and accumulators. x=0,1 carry no valid difference.
    always_comb begin
        edge_w    = s1_valid_q && (s1_m_q >= s1_thr_q) && (s1_x_q >= 10'd2);
        line_sum  = (s1_restart_q ? 10'd0 : line_acc_q) + {9'd0, edge_w};
        frame_sum = (s1_restart_q ? 19'd0 : frame_acc_q) + {18'd0, edge_w};

        out_valid_d   = s1_valid_q;
        out_edge_d    = edge_w;
        out_color_d   = edge_w ? 16'hFFFF : 16'h0000;
        line_acc_d    = line_acc_q;
        frame_acc_d   = frame_acc_q;
        line_count_d  = line_count_q;
        frame_count_d = frame_count_q;
        line_pulse_d  = 1'b0;
        frame_pulse_d = 1'b0;

        if (s1_valid_q) begin
            if (s1_last_line_q) begin
                line_count_d = line_sum;
                line_pulse_d = 1'b1;
                line_acc_d   = 10'd0;
            end else begin
                line_acc_d = line_sum;
            end
            if (s1_last_frame_q) begin
                frame_count_d = frame_sum;
                frame_pulse_d = 1'b1;
                frame_acc_d   = 19'd0;
            end else begin
                frame_acc_d = frame_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q             <= '0;
            y_q             <= '0;
            s1_valid_q      <= 1'b0;
            s1_m_q          <= '0;
            s1_thr_q        <= '0;
            s1_x_q          <= '0;
            s1_last_line_q  <= 1'b0;
            s1_last_frame_q <= 1'b0;
            s1_restart_q    <= 1'b0;
            out_valid_q     <= 1'b0;
            out_edge_q      <= 1'b0;
            out_color_q     <= '0;
            line_acc_q      <= '0;
            frame_acc_q     <= '0;
            line_count_q    <= '0;
            frame_count_q   <= '0;
            line_pulse_q    <= 1'b0;
            frame_pulse_q   <= 1'b0;
        end else begin
            x_q             <= x_d;
            y_q             <= y_d;
            s1_valid_q      <= s1_valid_d;
            s1_m_q          <= s1_m_d;
            s1_thr_q        <= s1_thr_d;
            s1_x_q          <= s1_x_d;
            s1_last_line_q  <= s1_last_line_d;
            s1_last_frame_q <= s1_last_frame_d;
            s1_restart_q    <= s1_restart_d;
            out_valid_q     <= out_valid_d;
            out_edge_q      <= out_edge_d;
            out_color_q     <= out_color_d;
            line_acc_q      <= line_acc_d;
            frame_acc_q     <= frame_acc_d;
            line_count_q    <= line_count_d;
            frame_count_q   <= frame_count_d;
            line_pulse_q    <= line_pulse_d;
            frame_pulse_q   <= frame_pulse_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_edge         = out_edge_q;
    assign out_color        = out_color_q;
    assign line_count       = line_count_q;
    assign line_count_valid = line_pulse_q;
    assign frame_count      = frame_count_q;
    assign frame_done       = frame_pulse_q;

endmodule

// File: tb/tb_edge_threshold_binarizer.sv
// Scoreboard bench: driver pushes reference-model expectations per pixel,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_edge_threshold_binarizer;
  localparam int H = 16;
  localparam int V = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_color;
  logic        frame_start;
  logic [7:0]  threshold;
  logic        out_valid;
  logic [15:0] out_color;
  logic        out_edge;
  logic [9:0]  line_count;
  logic        line_count_valid;
  logic [18:0] frame_count;
  logic        frame_done;

  edge_threshold_binarizer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_color(in_color),
    .frame_start(frame_start), .threshold(threshold), .out_valid(out_valid),
    .out_color(out_color), .out_edge(out_edge), .line_count(line_count),
    .line_count_valid(line_count_valid), .frame_count(frame_count),
    .frame_done(frame_done)
  );

  // clock / reset block
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // scoreboard state: {issue_cycle[63:32], fc[31:13], fp[12], lc[11:2], lp[1], edge[0]}
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [9:0]  hold_lc = '0;
  logic [18:0] hold_fc = '0;

  // reference model state
  int mx = 0, my = 0, lsum = 0, fsum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_push(input logic [15:0] c, input logic [7:0] t, input logic fs);
    int m, e, lp, fp, lc, fc;
    m = 2 * int'(c[15:11]) + int'(c[10:5]) + 2 * int'(c[4:0]);
    if (fs) begin
      mx = 0; my = 0; lsum = 0; fsum = 0;
    end
    e = (m >= int'(t) && mx >= 2) ? 1 : 0;
    lsum += e;
    fsum += e;
    lp = (mx == H - 1) ? 1 : 0;
    fp = (lp == 1 && my == V - 1) ? 1 : 0;
    lc = lp ? lsum : 0;
    fc = fp ? fsum : 0;
    if (lp) lsum = 0;
    if (fp) fsum = 0;
    if (mx == H - 1) begin
      mx = 0;
      my = (my == V - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
    exp_q.push_back({32'(cyc), 19'(fc), 1'(fp), 10'(lc), 1'(lp), 1'(e)});
  endtask

  // driver tasks
  task automatic pix(input logic [15:0] c, input logic [7:0] t, input logic fs);
    in_valid = 1'b1; in_color = c; threshold = t; frame_start = fs;
    model_push(c, t, fs);
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_color = 16'($urandom);
    frame_start = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic rand_pix(input int idle_pct, input logic fs);
    while ($urandom_range(0, 99) < idle_pct) idle();
    pix(16'($urandom), 8'($urandom_range(0, 200)), fs);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    hold_lc = '0; hold_fc = '0;
    mx = 0; my = 0; lsum = 0; fsum = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_edge", out_edge, 0);
    chk("rst_out_color", out_color, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_line_pulse", line_count_valid, 0);
    chk("rst_frame_pulse", frame_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e[63:32] + 32'd2);
          chk("out_edge", out_edge, e[0]);
          chk("out_color", out_color, e[0] ? 32'hFFFF : 32'h0);
          chk("line_pulse", line_count_valid, e[1]);
          chk("frame_pulse", frame_done, e[12]);
          if (e[1]) hold_lc = e[11:2];
          if (e[12]) hold_fc = e[31:13];
        end
      end else begin
        chk("idle_line_pulse", line_count_valid, 0);
        chk("idle_frame_pulse", frame_done, 0);
      end
      chk("line_count", line_count, hold_lc);
      chk("frame_count", frame_count, hold_fc);
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_color = '0; frame_start = 1'b0; threshold = '0;
    @(posedge clk); #1;
    do_reset();

    // all-black frame, threshold 1: no edges, frame_count 0
    for (int i = 0; i < H * V; i++) pix(16'h0000, 8'd1, i == 0);
    drain();
    chk("black_frame_count", frame_count, 0);

    // threshold boundaries on known magnitudes (FFFF -> 187, 0821 -> 5)
    for (int x = 0; x < H; x++) begin
      case (x)
        5: pix(16'hFFFF, 8'd187, 1'b0);
        6: pix(16'hFFFF, 8'd188, 1'b0);
        7: pix(16'h0821, 8'd5, 1'b0);
        8: pix(16'h0821, 8'd6, 1'b0);
        0, 1: pix(16'hFFFF, 8'd0, 1'b0);
        default: pix(16'($urandom), 8'($urandom_range(0, 200)), 1'b0);
      endcase
    end

    // full white frame at threshold 0, restarted by frame_start
    for (int i = 0; i < H * V; i++) pix(16'hFFFF, 8'd0, i == 0);
    drain();
    chk("white_frame_count", frame_count, (H - 2) * V);
    chk("white_line_count", line_count, H - 2);

    // random data with ~30% idle gaps across several frames
    for (int i = 0; i < 3 * H * V; i++) rand_pix(30, 1'b0);

    // mid-frame restart at (10,2)
    for (int i = 0; i < H * V; i++) begin
      if (mx == 10 && my == 2) break;
      rand_pix(20, i == 0);
    end
    rand_pix(20, 1'b1);
    for (int i = 0; i < 2 * H * V; i++) rand_pix(30, 1'b0);
    drain();

    // reset in the middle of a line, then a clean frame
    for (int i = 0; i < H + 7; i++) pix(16'hFFFF, 8'd0, i == 0);
    do_reset();
    for (int i = 0; i < H * V; i++) pix(16'hFFFF, 8'd0, 1'b0);
    drain();
    chk("post_reset_frame_count", frame_count, (H - 2) * V);
    for (int i = 0; i < H * V; i++) rand_pix(30, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
